pixel_streamer: RTL and testbench

PIXEL_STREAMER -- requirements
Module: pixel_streamer

---
 rtl/pixel_streamer_pkg.sv | 20 ++
 rtl/pixel_streamer_frame_buffer.sv | 34 +++
 rtl/pixel_streamer.sv | 115 +++++++++++
 tb/tb_pixel_streamer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_streamer_pkg.sv
// Shared frame geometry and FSM encoding for the pixel streamer.
// The defaults describe a 20x20 frame of 5-bit pixels sent to the core five lanes at a time.
package pixel_streamer_pkg;

    localparam int IMG_DIM    = 20;
    localparam int BIT_LENGTH = 5;
    localparam int LANES      = 5;
    localparam int TOTAL_PIX  = IMG_DIM * IMG_DIM;
    localparam int BEATS      = TOTAL_PIX / LANES;
    localparam int PIX_AW     = $clog2(TOTAL_PIX);
    localparam int BEAT_W     = $clog2(BEATS);

    typedef enum logic [1:0] {
        ST_FILL      = 2'd0,
        ST_BURST     = 2'd1,
        ST_WAIT_RD   = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/pixel_streamer_frame_buffer.sv
// Flop-based frame store: one serial write port and one LANES-wide beat read port.
// The contents are not reset, because every frame fully overwrites them before any read.
module frame_buffer #(
    parameter int DEPTH = 400,
    parameter int WIDTH = 5,
    parameter int LANES = 5,
    parameter int AW    = 9,
    parameter int BW    = 7
) (
    input  logic                         clk,
    input  logic                         we_i,
    input  logic [AW-1:0]                waddr_i,
    input  logic [WIDTH-1:0]             wdata_i,
    input  logic [BW-1:0]                rbeat_i,
    output logic [LANES-1:0][WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rbase;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Beat b covers pixels LANES*b .. LANES*b+LANES-1.
    assign rbase = AW'(rbeat_i) * AW'(LANES);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign rdata_o[k] = mem_q[rbase + AW'(k)];
    end

endmodule

// File: rtl/pixel_streamer.sv
// Collects one raster frame of serial pixels, then bursts it to the edge-detection core
// as contiguous LANES-wide beats and waits for the core to finish before taking the next frame.
module pixel_streamer #(
    parameter int IMG_DIM    = pixel_streamer_pkg::IMG_DIM,
    parameter int BIT_LENGTH = pixel_streamer_pkg::BIT_LENGTH,
    parameter int LANES      = pixel_streamer_pkg::LANES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BIT_LENGTH-1:0] pix_in,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    output logic [BIT_LENGTH-1:0] pixel_out0,
    output logic [BIT_LENGTH-1:0] pixel_out1,
    output logic [BIT_LENGTH-1:0] pixel_out2,
    output logic [BIT_LENGTH-1:0] pixel_out3,
    output logic [BIT_LENGTH-1:0] pixel_out4,
    output logic                  load_end,
    input  logic                  chip_readable,
    output logic                  busy,
    output logic                  frame_done,
    output logic [1:0]            state_o
);
    import pixel_streamer_pkg::*;

    localparam int FRAME_PIX   = IMG_DIM * IMG_DIM;
    localparam int FRAME_BEATS = FRAME_PIX / LANES;
    localparam int ADDR_W      = $clog2(FRAME_PIX);
    localparam int CNT_W       = $clog2(FRAME_BEATS);

    localparam logic [ADDR_W-1:0] LAST_PIX  = ADDR_W'(FRAME_PIX - 1);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(FRAME_BEATS - 1);

    state_t                           state_q;
    logic [ADDR_W-1:0]                wr_idx_q;
    logic [CNT_W-1:0]                 beat_q;
    logic                             handshake;
    logic                             burst_active;
    logic [LANES-1:0][BIT_LENGTH-1:0] rd_lanes;

    // Upstream valid/ready: a pixel transfers on a rising edge where pix_valid and
    // pix_ready are both high; pix_ready is high exactly in FILL and does not depend
    // on pix_valid, and the source holds pix_in stable until the transfer occurs.
    assign pix_ready    = (state_q == ST_FILL);
    assign handshake    = pix_valid && pix_ready;
    assign burst_active = (state_q == ST_BURST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_FILL;
            wr_idx_q <= '0;
            beat_q   <= '0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (handshake) begin
                        if (wr_idx_q == LAST_PIX) begin
                            wr_idx_q <= '0;
                            state_q  <= ST_BURST;
                        end else begin
                            wr_idx_q <= wr_idx_q + 1'b1;
                        end
                    end
                end
                ST_BURST: begin
                    if (beat_q == LAST_BEAT) begin
                        beat_q  <= '0;
                        state_q <= ST_WAIT_RD;
                    end else begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                ST_WAIT_RD: begin
                    if (chip_readable) begin
                        state_q <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!chip_readable) begin
                        state_q <= ST_FILL;
                    end
                end
                default: state_q <= ST_FILL;
            endcase
        end
    end

    frame_buffer #(
        .DEPTH (FRAME_PIX),
        .WIDTH (BIT_LENGTH),
        .LANES (LANES),
        .AW    (ADDR_W),
        .BW    (CNT_W)
    ) u_frame_buffer (
        .clk     (clk),
        .we_i    (handshake),
        .waddr_i (wr_idx_q),
        .wdata_i (pix_in),
        .rbeat_i (beat_q),
        .rdata_o (rd_lanes)
    );

    // Lanes are gated by the state register, so an asynchronous reset blanks them at once.
    assign pixel_out0 = burst_active ? rd_lanes[0] : '0;
    assign pixel_out1 = burst_active ? rd_lanes[1] : '0;
    assign pixel_out2 = burst_active ? rd_lanes[2] : '0;
    assign pixel_out3 = burst_active ? rd_lanes[3] : '0;
    assign pixel_out4 = burst_active ? rd_lanes[4] : '0;

    assign load_end   = burst_active && (beat_q == LAST_BEAT);
    assign frame_done = (state_q == ST_WAIT_DONE) && !chip_readable;
    assign busy       = (state_q != ST_FILL);
    assign state_o    = state_q;

endmodule

// File: tb/tb_pixel_streamer.sv
// Self-checking bench for pixel_streamer: frames are modelled as plain pixel arrays and
// every beat, strobe and pulse is predicted from the frame-level behaviour.
module tb_pixel_streamer;

    localparam int N     = 400;
    localparam int BEATS = 80;
    localparam int LANES = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] pix_in;
    logic       pix_valid;
    logic       pix_ready;
    logic [4:0] po0, po1, po2, po3, po4;
    logic       load_end;
    logic       chip_readable;
    logic       busy;
    logic       frame_done;
    logic [1:0] state_o;

    int n_tests  = 0;
    int n_fail   = 0;
    int exp_pix[N];
    int done_cnt = 0;
    int exp_done = 0;
    int load_cnt = 0;
    int exp_load = 0;

    always #5 clk = ~clk;

    pixel_streamer dut (
        .clk           (clk),
        .reset         (reset),
        .pix_in        (pix_in),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .pixel_out0    (po0),
        .pixel_out1    (po1),
        .pixel_out2    (po2),
        .pixel_out3    (po3),
        .pixel_out4    (po4),
        .load_end      (load_end),
        .chip_readable (chip_readable),
        .busy          (busy),
        .frame_done    (frame_done),
        .state_o       (state_o)
    );

    always @(negedge clk) begin
        if (frame_done) done_cnt++;
        if (load_end)   load_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] lanes_got();
        return 32'({po4, po3, po2, po1, po0});
    endfunction

    function automatic logic [31:0] lanes_exp(input int b);
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < LANES; k++) begin
            v[k*5 +: 5] = 5'(exp_pix[LANES*b + k]);
        end
        return v;
    endfunction

    // kind: 0 ramp (i mod 32), 1 random, otherwise a constant value equal to kind
    task automatic gen_frame(input int kind);
        for (int i = 0; i < N; i++) begin
            if (kind == 0)      exp_pix[i] = i % 32;
            else if (kind == 1) exp_pix[i] = int'($urandom_range(0, 31));
            else                exp_pix[i] = kind;
        end
    endtask

    task automatic drive_junk(input bit junk);
        if (junk) begin
            pix_valid = 1'b1;
            pix_in    = 5'($urandom_range(0, 31));
        end else begin
            pix_valid = 1'b0;
        end
    endtask

    task automatic fill_frame(input bit toggle);
        int i;
        int cyc;
        bit v;
        i   = 0;
        cyc = 0;
        while (i < N) begin
            v             = toggle ? (cyc % 2 == 0) : 1'b1;
            pix_valid     = v;
            pix_in        = v ? 5'(exp_pix[i]) : 5'($urandom_range(0, 31));
            chip_readable = 1'($urandom_range(0, 1));
            #1;
            if (v) check("fill_ready", 32'(pix_ready), 1);
            if (i == 0 || i == N - 1) begin
                check("fill_busy", 32'(busy), 0);
                check("fill_lanes_zero", lanes_got(), 0);
            end
            tick();
            if (v) i++;
            cyc++;
        end
        check("fill_cycles", 32'(cyc), toggle ? 799 : 400);
    endtask

    // Returns with reset held low when abort_at hits a beat index.
    task automatic run_burst(input bit junk, input int abort_at);
        bit aborted;
        aborted = 1'b0;
        for (int b = 0; b < BEATS; b++) begin
            if (!aborted) begin
                drive_junk(junk);
                chip_readable = 1'($urandom_range(0, 1));
                if (b == abort_at) begin
                    reset     = 1'b0;
                    pix_valid = 1'b0;
                    #1;
                    check("abort_lanes_zero", lanes_got(), 0);
                    check("abort_load_end", 32'(load_end), 0);
                    check("abort_busy", 32'(busy), 0);
                    aborted = 1'b1;
                end else begin
                    #1;
                    check("burst_lanes", lanes_got(), lanes_exp(b));
                    check("burst_load_end", 32'(load_end), (b == BEATS - 1) ? 1 : 0);
                    check("burst_ready", 32'(pix_ready), 0);
                    check("burst_busy", 32'(busy), 1);
                    if (b == BEATS - 1) exp_load++;
                    tick();
                end
            end
        end
    endtask

    task automatic core_handshake(input int lo, input int hi, input bit junk);
        check("load_end_count", 32'(load_cnt), 32'(exp_load));
        chip_readable = 1'b0;
        for (int c = 0; c < lo; c++) begin
            drive_junk(junk);
            #1;
            check("wait_rd_done", 32'(frame_done), 0);
            check("wait_rd_busy", 32'(busy), 1);
            check("wait_rd_ready", 32'(pix_ready), 0);
            check("wait_rd_outputs", lanes_got() | 32'(load_end), 0);
            tick();
        end
        chip_readable = 1'b1;
        for (int c = 0; c < hi; c++) begin
            drive_junk(junk);
            #1;
            check("wait_hi_done", 32'(frame_done), 0);
            if (c == 0 || c == hi - 1) check("wait_hi_busy", 32'(busy), 1);
            tick();
        end
        chip_readable = 1'b0;
        drive_junk(junk);
        #1;
        check("frame_done_pulse", 32'(frame_done), 1);
        exp_done++;
        tick();
        pix_valid = 1'b0;
        #1;
        check("after_done_ready", 32'(pix_ready), 1);
        check("after_done_busy", 32'(busy), 0);
        check("after_done_pulse_end", 32'(frame_done), 0);
        check("frame_done_count", 32'(done_cnt), 32'(exp_done));
    endtask

    initial begin
        reset         = 1'b0;
        pix_in        = '0;
        pix_valid     = 1'b0;
        chip_readable = 1'b0;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_load_end", 32'(load_end), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_lanes", lanes_got(), 0);
        reset = 1'b1;
        #1;
        check("rst_release_ready", 32'(pix_ready), 1);

        // Ramp frame, core timing 10 low / 400 high / low
        gen_frame(0);
        fill_frame(1'b0);
        run_burst(1'b0, -1);
        core_handshake(10, 400, 1'b0);

        // Same ramp with pix_valid toggling every cycle
        gen_frame(0);
        fill_frame(1'b1);
        run_burst(1'b0, -1);
        core_handshake(int'($urandom_range(0, 6)), int'($urandom_range(1, 8)), 1'b1);

        // Random frames with junk offered while not filling
        for (int f = 0; f < 2; f++) begin
            gen_frame(1);
            fill_frame(1'b0);
            run_burst(1'b1, -1);
            core_handshake(int'($urandom_range(0, 6)), int'($urandom_range(1, 8)), 1'b1);
        end

        // Reset in the middle of a burst discards the frame
        gen_frame(1);
        fill_frame(1'b0);
        run_burst(1'b1, 40);
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("reset_abort_ready", 32'(pix_ready), 1);
        check("reset_abort_busy", 32'(busy), 0);
        gen_frame(1);
        fill_frame(1'b0);
        run_burst(1'b0, -1);
        core_handshake(int'($urandom_range(0, 6)), int'($urandom_range(1, 8)), 1'b0);

        // Back-to-back constant frames
        gen_frame(7);
        fill_frame(1'b0);
        run_burst(1'b1, -1);
        core_handshake(3, 5, 1'b1);
        gen_frame(21);
        fill_frame(1'b0);
        run_burst(1'b1, -1);
        core_handshake(2, 2, 1'b0);

        repeat (2) tick();
        check("total_load_end", 32'(load_cnt), 32'(exp_load));
        check("total_frame_done", 32'(done_cnt), 32'(exp_done));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
